fir4_inverse: RTL
=================

Name: fir4_inverse

Overview:
- Sequential inverse (all-pole deconvolution) filter for the 4-tap integer FIR datapath.
- Recovers the original 8-bit sample stream x[n] from the 16-bit FIR output stream y[n]: x[n] = y[n] − H1·x[n−1] − H2·x[n−2] − H3·x[n−3], with H0 ≡ 1.
- Sits on the receive side of the filtered link. Uses a single time-multiplexed multiply-subtract unit.
- Valid/ready handshakes on both the input and output sides.

Parameters:
- H1, 8'sd2, signed tap-1 coefficient; must equal the transmit-side FIR H1.
- H2, 8'sd3, signed tap-2 coefficient.
- H3, 8'sd4, signed tap-3 coefficient.
- H0 is not a parameter. The block is defined only for H0 = 1.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- y_in  input  16  signed FIR output sample.
- in_valid  input  1  y_in is valid.
- in_ready  output  1  block can accept a sample; combinational, = (state==IDLE) && !hist_clr.
- hist_clr  input  1  clears history and sat_err; honoured only in IDLE.
- x_out  output  8  signed recovered sample, registered.
- out_valid  output  1  x_out is valid.
- out_ready  input  1  downstream accepts x_out.
- sat_err  output  1  sticky flag: a result was saturated.

Behaviour:
- Reset, evaluated at a clock edge with rst_n=0; applies in any state, including mid-MAC:
  - state=IDLE.
  - x_out=0, out_valid=0, sat_err=0.
  - History h0=h1=h2=0, where h0 = x[n−1], h1 = x[n−2], h2 = x[n−3].
  - Accumulator = 0.
- States are IDLE, MAC1, MAC2, MAC3, OUT.
- Accumulator is 20-bit signed. It holds 16-bit input + 3 × (8×8) products without overflow.
- Arithmetic is full precision, with no intermediate truncation.
- IDLE:
  - hist_clr=1 → h0..h2 ← 0, sat_err ← 0, no sample accepted; stay in IDLE.
  - Otherwise, on in_valid=1 at edge T: acc ← sign-extended y_in; go to MAC1.
- MAC1, at edge T+1: acc ← acc − H1·h0; go to MAC2.
- MAC2, at edge T+2: acc ← acc − H2·h1; go to MAC3.
- MAC3, at edge T+3:
  - r = acc − H3·h2.
  - x_out ← sat8(r), where sat8 clamps to [−128, 127].
  - sat_err ← sat_err | (r out of range).
  - History shifts: h2←h1, h1←h0, h0←sat8(r).
  - out_valid ← 1; go to OUT.
- OUT:
  - x_out and out_valid hold stable until out_ready=1.
  - On the edge where out_valid && out_ready: out_valid ← 0, go to IDLE. x_out retains its last value.
- Latency: out_valid rises at edge T+3 after acceptance at edge T.
- Minimum initiation interval is 5 cycles, with out_ready held high.
- in_ready=0 in MAC1..OUT. in_valid in those states is ignored and must be held by the upstream.
- hist_clr outside IDLE is ignored.
- History updates only in MAC3. It is never altered by backpressure or by ignored inputs.
- Exact inversion holds whenever the original x[n] lies in the 8-bit range.

Test Plan:
- Reset, then drive y_in = 5, 7, 19, 31 with in_valid held high and out_ready=1 → x_out sequence is 5, −3, 10, 0, with out_valid rising 3 cycles after each accept and sat_err=0.
- Reset, y_in=300 → x_out=127, sat_err=1. Then hist_clr pulse in IDLE → sat_err=0. Then y_in=0 → x_out=0 (history cleared).
- Reset, y_in=−200 → x_out=−128 and sat_err=1. Next y_in=0 → x_out = 0 − 2·(−128) = 256, saturates to 127, sat_err stays 1.
- Backpressure: after y_in=5, hold out_ready=0 for 6 cycles → out_valid and x_out=5 stay stable, in_ready stays 0, and y_in changes during the stall are ignored. Release → handshake, IDLE, in_ready=1 the next cycle.
- Mid-operation reset: accept y_in=7, assert rst_n=0 during MAC2 → next cycle state is IDLE, out_valid=0, x_out=0. Then y_in=5 → x_out=5, proving history was zeroed.
- Overrides: H1=−1, H2=0, H3=1 with y_in = 3, 4, 5 → x_out = 3, 7, 12.

Source files
------------

// File: rtl/fir4_inverse.sv
// All-pole inverse of the 4-tap FIR: x[n] = y[n] - H1*x[n-1] - H2*x[n-2] - H3*x[n-3], one shared multiply-subtract unit.
// Latency: out_valid rises 3 edges after accept; in_ready low from accept until the output handshake completes.
module fir4_inverse #(
    parameter logic signed [7:0] H1 = 8'sd2,
    parameter logic signed [7:0] H2 = 8'sd3,
    parameter logic signed [7:0] H3 = 8'sd4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] y_in,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        hist_clr,
    output logic [7:0]  x_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        sat_err
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] MAC1 = 3'd1;
    localparam logic [2:0] MAC2 = 3'd2;
    localparam logic [2:0] MAC3 = 3'd3;
    localparam logic [2:0] OUT  = 3'd4;

    logic [2:0]         state;
    logic signed [19:0] acc;
    logic signed [7:0]  h0, h1, h2;

    logic signed [7:0]  coef;
    logic signed [7:0]  opnd;
    logic signed [15:0] prod;
    logic signed [19:0] acc_sub;
    logic signed [7:0]  r_sat;
    logic               r_ovf;

    assign in_ready = (state == IDLE) && !hist_clr;

    // Shared multiply-subtract: each MAC state picks its tap and history word.
    always_comb begin
        coef = 8'sd0;
        opnd = 8'sd0;
        case (state)
            MAC1: begin coef = H1; opnd = h0; end
            MAC2: begin coef = H2; opnd = h1; end
            MAC3: begin coef = H3; opnd = h2; end
            default: begin coef = 8'sd0; opnd = 8'sd0; end
        endcase
        prod    = 16'(coef) * 16'(opnd);
        acc_sub = acc - $signed({{4{prod[15]}}, prod});
        r_ovf   = (acc_sub > 20'sd127) || (acc_sub < -20'sd128);
        if (acc_sub > 20'sd127)
            r_sat = 8'sd127;
        else if (acc_sub < -20'sd128)
            r_sat = -8'sd128;
        else
            r_sat = acc_sub[7:0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            acc       <= '0;
            h0        <= '0;
            h1        <= '0;
            h2        <= '0;
            x_out     <= '0;
            out_valid <= 1'b0;
            sat_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hist_clr) begin
                        h0      <= '0;
                        h1      <= '0;
                        h2      <= '0;
                        sat_err <= 1'b0;
                    end else if (in_valid) begin
                        acc   <= {{4{y_in[15]}}, y_in};
                        state <= MAC1;
                    end
                end
                MAC1: begin
                    acc   <= acc_sub;
                    state <= MAC2;
                end
                MAC2: begin
                    acc   <= acc_sub;
                    state <= MAC3;
                end
                MAC3: begin
                    // The saturated value, not the raw result, feeds back as history.
                    acc       <= acc_sub;
                    x_out     <= r_sat;
                    sat_err   <= sat_err | r_ovf;
                    h2        <= h1;
                    h1        <= h0;
                    h0        <= r_sat;
                    out_valid <= 1'b1;
                    state     <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
